// File: rtl/mpu_load_if.sv
// Load-path bundle for mpu_load: memory element stream in, register-file write port out.
// The slave modport is the loader itself; master is whatever drives it.
interface mpu_load_if #(
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_BITS = 3,
  parameter int FP_BITS         = 32
);
  logic                       load_req_in;
  logic [MBITS:0]             mem_m_load_size_in;
  logic [NBITS:0]             mem_n_load_size_in;
  logic [MATRIX_REG_BITS:0]   mem_load_addr_in;
  logic                       mem_load_valid_in;
  logic [FP_BITS-1:0]         mem_load_element_in;
  logic                       mem_load_ack_out;
  logic                       reg_load_ready_in;
  logic                       reg_load_req_out;
  logic                       reg_load_en_out;
  logic [FP_BITS-1:0]         reg_load_element_out;
  logic [MBITS:0]             reg_i_load_loc_out;
  logic [NBITS:0]             reg_j_load_loc_out;
  logic [MBITS:0]             reg_m_load_size_out;
  logic [NBITS:0]             reg_n_load_size_out;
  logic [MATRIX_REG_BITS:0]   reg_load_addr_out;
  logic                       load_busy_out;
  logic                       load_done_out;

  modport slave (
    input  load_req_in, mem_m_load_size_in, mem_n_load_size_in, mem_load_addr_in,
           mem_load_valid_in, mem_load_element_in, reg_load_ready_in,
    output mem_load_ack_out, reg_load_req_out, reg_load_en_out, reg_load_element_out,
           reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out,
           reg_n_load_size_out, reg_load_addr_out, load_busy_out, load_done_out
  );

  modport master (
    output load_req_in, mem_m_load_size_in, mem_n_load_size_in, mem_load_addr_in,
           mem_load_valid_in, mem_load_element_in, reg_load_ready_in,
    input  mem_load_ack_out, reg_load_req_out, reg_load_en_out, reg_load_element_out,
           reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out,
           reg_n_load_size_out, reg_load_addr_out, load_busy_out, load_done_out
  );
endinterface

// File: rtl/mpu_load.sv
// Streams an M x N matrix from memory into a register-file entry, row-major,
// one registered write per accepted element.
//
// state        | meaning
// LOAD_IDLE    | waiting for load_req_in; latches M, N, address on request
// LOAD_REQUEST | asking the register file for the write port
// LOAD_MATRIX  | accepting elements, ack follows valid
// LOAD_DONE    | one-cycle completion pulse (final write strobe lands here)
module mpu_load #(
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_BITS = 3,
  parameter int FP_BITS         = 32
) (
  input  logic       clk,
  input  logic       rst,
  mpu_load_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD_IDLE    = 2'd0,
    LOAD_REQUEST = 2'd1,
    LOAD_MATRIX  = 2'd2,
    LOAD_DONE    = 2'd3
  } state_t;

  localparam logic [MBITS:0] M_ONE = 1;
  localparam logic [NBITS:0] N_ONE = 1;

  state_t                     state, state_nxt;
  logic [MBITS:0]             m_q, rp, i_q;
  logic [NBITS:0]             n_q, cp, j_q;
  logic [MATRIX_REG_BITS:0]   addr_q;
  logic [FP_BITS-1:0]         elem_q;
  logic                       en_q;
  logic                       accept, row_end, last;

  assign accept  = (state == LOAD_MATRIX) && bus.mem_load_valid_in;
  assign row_end = (cp == n_q - N_ONE);
  assign last    = row_end && (rp == m_q - M_ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_IDLE: begin
        if (bus.load_req_in) begin
          // Empty matrices skip the register-file handshake entirely.
          if ((bus.mem_m_load_size_in == '0) || (bus.mem_n_load_size_in == '0))
            state_nxt = LOAD_DONE;
          else
            state_nxt = LOAD_REQUEST;
        end
      end
      LOAD_REQUEST: if (bus.reg_load_ready_in) state_nxt = LOAD_MATRIX;
      LOAD_MATRIX:  if (accept && last)        state_nxt = LOAD_DONE;
      LOAD_DONE:    state_nxt = LOAD_IDLE;
      default:      state_nxt = LOAD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= LOAD_IDLE;
      m_q    <= '0;
      n_q    <= '0;
      addr_q <= '0;
      rp     <= '0;
      cp     <= '0;
      en_q   <= 1'b0;
      elem_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else begin
      state <= state_nxt;
      en_q  <= accept;
      if ((state == LOAD_IDLE) && bus.load_req_in) begin
        m_q    <= bus.mem_m_load_size_in;
        n_q    <= bus.mem_n_load_size_in;
        addr_q <= bus.mem_load_addr_in;
        rp     <= '0;
        cp     <= '0;
      end
      if (accept) begin
        elem_q <= bus.mem_load_element_in;
        i_q    <= rp;
        j_q    <= cp;
        // Pointers park on the final element rather than wrapping.
        if (!last) begin
          if (row_end) begin
            cp <= '0;
            rp <= rp + M_ONE;
          end else begin
            cp <= cp + N_ONE;
          end
        end
      end
    end
  end

  assign bus.mem_load_ack_out     = accept;
  assign bus.reg_load_req_out     = (state == LOAD_REQUEST);
  assign bus.reg_load_en_out      = en_q;
  assign bus.reg_load_element_out = elem_q;
  assign bus.reg_i_load_loc_out   = i_q;
  assign bus.reg_j_load_loc_out   = j_q;
  assign bus.reg_m_load_size_out  = m_q;
  assign bus.reg_n_load_size_out  = n_q;
  assign bus.reg_load_addr_out    = addr_q;
  assign bus.load_busy_out        = (state != LOAD_IDLE);
  assign bus.load_done_out        = (state == LOAD_DONE);

endmodule

// File: tb/tb_mpu_load.sv
// Directed bench for mpu_load: one task per scenario, expectations hand-derived
// from cycle numbers counted from the request cycle (c = 0).
module tb_mpu_load;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mpu_load_if #(.MBITS(2), .NBITS(2), .MATRIX_REG_BITS(3), .FP_BITS(32)) bus ();

  mpu_load #(.MBITS(2), .NBITS(2), .MATRIX_REG_BITS(3), .FP_BITS(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;

  // Observations captured by run_load
  int          w_i[16], w_j[16], w_cyc[16], ack_cyc[16], done_cyc[4];
  logic [31:0] w_d[16];
  int          nw, nack, ndone, req_cnt, ack_inval, gap_chg, timed_out;
  logic        busy_after, abort_or;
  logic [2:0]  lat_m, lat_n;
  logic [3:0]  lat_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_req_in         = 1'b0;
    bus.mem_m_load_size_in  = '0;
    bus.mem_n_load_size_in  = '0;
    bus.mem_load_addr_in    = '0;
    bus.mem_load_valid_in   = 1'b0;
    bus.mem_load_element_in = '0;
    bus.reg_load_ready_in   = 1'b0;
  endtask

  // Drives one load and records what the DUT does; comparisons live in the tests.
  task automatic run_load(input logic [2:0] m, input logic [2:0] n, input logic [3:0] a,
                          input int rdy_dly, input bit toggle, input int req_pulse_at,
                          input int abort_at, input bit hold_req);
    int   eidx, done_seen;
    bit   finished, ack_s;
    logic [2:0]  pi, pj;
    logic [31:0] pd;
    for (int k = 0; k < 16; k++) begin
      w_i[k] = -1; w_j[k] = -1; w_cyc[k] = -1; ack_cyc[k] = -1; w_d[k] = 'x;
    end
    for (int k = 0; k < 4; k++) done_cyc[k] = -1;
    nw = 0; nack = 0; ndone = 0; req_cnt = 0; ack_inval = 0; gap_chg = 0;
    timed_out = 0; busy_after = 1'bx; abort_or = 1'bx;
    lat_m = 'x; lat_n = 'x; lat_a = 'x;
    eidx = 0; done_seen = -1; finished = 0;
    pi = '0; pj = '0; pd = '0;
    for (int c = 0; c < 60; c++) begin
      bus.load_req_in         = (c == 0) || (c == req_pulse_at) || hold_req;
      bus.mem_m_load_size_in  = (c == 0) ? m : 3'd7;
      bus.mem_n_load_size_in  = (c == 0) ? n : 3'd7;
      bus.mem_load_addr_in    = (c == 0) ? a : 4'hf;
      bus.reg_load_ready_in   = (c >= rdy_dly);
      bus.mem_load_valid_in   = toggle ? ((c % 2) == 0) : 1'b1;
      bus.mem_load_element_in = 32'h1000 + 32'(eidx);
      if (c == abort_at) begin
        rst = 1'b0;
        #1;
        abort_or = |{bus.reg_load_en_out, bus.mem_load_ack_out, bus.reg_load_req_out,
                     bus.load_busy_out, bus.load_done_out, bus.reg_load_element_out,
                     bus.reg_i_load_loc_out, bus.reg_j_load_loc_out,
                     bus.reg_m_load_size_out, bus.reg_n_load_size_out,
                     bus.reg_load_addr_out};
        idle_inputs();
        return;
      end
      @(negedge clk);
      ack_s = bus.mem_load_ack_out;
      if (bus.load_done_out) begin
        if (ndone < 4) done_cyc[ndone] = c;
        ndone++;
        done_seen = c;
        lat_m = bus.reg_m_load_size_out;
        lat_n = bus.reg_n_load_size_out;
        lat_a = bus.reg_load_addr_out;
      end
      if (ack_s) begin
        if (nack < 16) ack_cyc[nack] = c;
        nack++;
        if (!bus.mem_load_valid_in) ack_inval++;
      end
      if (bus.reg_load_req_out) req_cnt++;
      if (bus.reg_load_en_out) begin
        if (nw < 16) begin
          w_i[nw] = int'(bus.reg_i_load_loc_out);
          w_j[nw] = int'(bus.reg_j_load_loc_out);
          w_d[nw] = bus.reg_load_element_out;
          w_cyc[nw] = c;
        end
        nw++;
      end else if (nw > 0) begin
        if (bus.reg_i_load_loc_out !== pi || bus.reg_j_load_loc_out !== pj ||
            bus.reg_load_element_out !== pd) gap_chg++;
      end
      pi = bus.reg_i_load_loc_out;
      pj = bus.reg_j_load_loc_out;
      pd = bus.reg_load_element_out;
      if (done_seen >= 0 && c == done_seen + 1) begin
        busy_after = bus.load_busy_out;
        finished = 1;
        break;
      end
      tick();
      if (ack_s) eidx++;
    end
    if (!finished) timed_out = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick(); tick();
    @(negedge clk);
    vecs++;
    if (bus.load_busy_out !== 1'b0) begin
      errs++; $display("FAIL reset_busy: got %b expected 0", bus.load_busy_out);
    end
    vecs++;
    if (|{bus.reg_load_en_out, bus.mem_load_ack_out, bus.reg_load_req_out, bus.load_done_out,
          bus.reg_load_element_out, bus.reg_i_load_loc_out, bus.reg_j_load_loc_out,
          bus.reg_m_load_size_out, bus.reg_n_load_size_out, bus.reg_load_addr_out} !== 1'b0) begin
      errs++; $display("FAIL reset_outputs: some output nonzero, expected all 0");
    end
    tick();
    rst = 1'b1;
    bus.mem_load_valid_in = 1'b1;
    bus.reg_load_ready_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vecs++;
      if (bus.load_busy_out !== 1'b0 || bus.mem_load_ack_out !== 1'b0) begin
        errs++; $display("FAIL reset_stay_idle: busy=%b ack=%b expected 0 0",
                         bus.load_busy_out, bus.mem_load_ack_out);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full_load();
    run_load(3'd2, 3'd3, 4'd5, 0, 1'b0, -1, -1, 1'b0);
    vecs++;
    if (timed_out != 0) begin errs++; $display("FAIL full_timeout: no done pulse within budget"); end
    vecs++;
    if (nw != 6) begin errs++; $display("FAIL full_writes: got %0d expected 6", nw); end
    for (int k = 0; k < 6; k++) begin
      vecs++;
      if (w_i[k] != k / 3 || w_j[k] != k % 3 || w_d[k] !== 32'h1000 + 32'(k) || w_cyc[k] != 3 + k) begin
        errs++;
        $display("FAIL full_write%0d: got i=%0d j=%0d d=%h cyc=%0d expected i=%0d j=%0d d=%h cyc=%0d",
                 k, w_i[k], w_j[k], w_d[k], w_cyc[k], k / 3, k % 3, 32'h1000 + 32'(k), 3 + k);
      end
    end
    vecs++;
    if (ndone != 1 || done_cyc[0] != 8) begin
      errs++; $display("FAIL full_done: got %0d pulses at %0d expected 1 at 8", ndone, done_cyc[0]);
    end
    vecs++;
    if (lat_m !== 3'd2 || lat_n !== 3'd3 || lat_a !== 4'd5) begin
      errs++; $display("FAIL full_latched: got m=%0d n=%0d a=%0d expected 2 3 5", lat_m, lat_n, lat_a);
    end
    vecs++;
    if (busy_after !== 1'b0) begin errs++; $display("FAIL full_idle_after: busy=%b expected 0", busy_after); end
  endtask

  task automatic test_valid_gaps();
    run_load(3'd2, 3'd2, 4'd3, 0, 1'b1, -1, -1, 1'b0);
    vecs++;
    if (nack != 4 || ack_inval != 0) begin
      errs++; $display("FAIL gaps_acks: got %0d acks (%0d on invalid) expected 4 (0)", nack, ack_inval);
    end
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (ack_cyc[k] != 2 + 2 * k || w_cyc[k] != 3 + 2 * k || w_i[k] != k / 2 || w_j[k] != k % 2 ||
          w_d[k] !== 32'h1000 + 32'(k)) begin
        errs++;
        $display("FAIL gaps_write%0d: got ack@%0d wr@%0d i=%0d j=%0d d=%h expected ack@%0d wr@%0d i=%0d j=%0d",
                 k, ack_cyc[k], w_cyc[k], w_i[k], w_j[k], w_d[k], 2 + 2 * k, 3 + 2 * k, k / 2, k % 2);
      end
    end
    vecs++;
    if (gap_chg != 0) begin errs++; $display("FAIL gaps_hold: outputs changed in %0d gap cycles expected 0", gap_chg); end
    vecs++;
    if (nw != 4 || ndone != 1 || done_cyc[0] != 9) begin
      errs++; $display("FAIL gaps_done: writes=%0d done=%0d@%0d expected 4 1@9", nw, ndone, done_cyc[0]);
    end
  endtask

  task automatic test_ready_delay();
    run_load(3'd1, 3'd2, 4'd1, 5, 1'b0, -1, -1, 1'b0);
    vecs++;
    if (req_cnt != 5) begin errs++; $display("FAIL delay_req_cycles: got %0d expected 5", req_cnt); end
    vecs++;
    if (ack_cyc[0] != 6 || nack != 2) begin
      errs++; $display("FAIL delay_first_ack: got %0d acks first@%0d expected 2 first@6", nack, ack_cyc[0]);
    end
    vecs++;
    if (nw != 2 || ndone != 1 || done_cyc[0] != 8 || w_j[1] != 1) begin
      errs++; $display("FAIL delay_done: writes=%0d done=%0d@%0d expected 2 1@8", nw, ndone, done_cyc[0]);
    end
  endtask

  task automatic test_zero_size();
    run_load(3'd0, 3'd3, 4'd2, 0, 1'b0, -1, -1, 1'b0);
    vecs++;
    if (ndone != 1 || done_cyc[0] != 1) begin
      errs++; $display("FAIL zero_done: got %0d pulses at %0d expected 1 at 1", ndone, done_cyc[0]);
    end
    vecs++;
    if (nw != 0 || nack != 0 || req_cnt != 0) begin
      errs++; $display("FAIL zero_activity: writes=%0d acks=%0d reqs=%0d expected 0 0 0", nw, nack, req_cnt);
    end
    vecs++;
    if (busy_after !== 1'b0 || lat_m !== 3'd0 || lat_n !== 3'd3) begin
      errs++; $display("FAIL zero_idle: busy=%b m=%0d n=%0d expected 0 0 3", busy_after, lat_m, lat_n);
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    run_load(3'd2, 3'd2, 4'd4, 0, 1'b0, -1, 5, 1'b0);
    vecs++;
    if (nack != 3) begin errs++; $display("FAIL abort_acks_before: got %0d expected 3", nack); end
    vecs++;
    if (abort_or !== 1'b0) begin errs++; $display("FAIL abort_outputs: got nonzero outputs expected all 0"); end
    tick(); tick();
    rst = 1'b1;
    bus.mem_load_valid_in = 1'b1;
    bus.reg_load_ready_in = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.reg_load_en_out || bus.load_busy_out || bus.mem_load_ack_out) bad++;
      tick();
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL abort_quiet: %0d active cycles after reset expected 0", bad); end
    idle_inputs();
    run_load(3'd1, 3'd1, 4'd3, 0, 1'b0, -1, -1, 1'b0);
    vecs++;
    if (nw != 1 || w_i[0] != 0 || w_j[0] != 0 || w_d[0] !== 32'h1000 || w_cyc[0] != 3 ||
        done_cyc[0] != 3 || ndone != 1) begin
      errs++; $display("FAIL abort_fresh_load: writes=%0d i=%0d j=%0d d=%h wr@%0d done@%0d expected 1 0 0 1000 3 3",
                       nw, w_i[0], w_j[0], w_d[0], w_cyc[0], done_cyc[0]);
    end
  endtask

  task automatic test_req_ignored();
    run_load(3'd2, 3'd2, 4'd6, 0, 1'b0, 3, -1, 1'b0);
    vecs++;
    if (nw != 4 || ndone != 1 || done_cyc[0] != 6) begin
      errs++; $display("FAIL ignore_done: writes=%0d done=%0d@%0d expected 4 1@6", nw, ndone, done_cyc[0]);
    end
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (w_i[k] != k / 2 || w_j[k] != k % 2 || w_d[k] !== 32'h1000 + 32'(k)) begin
        errs++; $display("FAIL ignore_write%0d: got i=%0d j=%0d d=%h expected i=%0d j=%0d",
                         k, w_i[k], w_j[k], w_d[k], k / 2, k % 2);
      end
    end
    vecs++;
    if (lat_m !== 3'd2 || lat_n !== 3'd2 || lat_a !== 4'd6) begin
      errs++; $display("FAIL ignore_latched: got m=%0d n=%0d a=%0d expected 2 2 6", lat_m, lat_n, lat_a);
    end
  endtask

  task automatic test_back_to_back();
    run_load(3'd1, 3'd1, 4'd7, 0, 1'b0, -1, -1, 1'b1);
    vecs++;
    if (nw != 1 || done_cyc[0] != 3 || busy_after !== 1'b0) begin
      errs++; $display("FAIL b2b_first: writes=%0d done@%0d busy_after=%b expected 1 3 0",
                       nw, done_cyc[0], busy_after);
    end
    vecs++;
    if (bus.load_busy_out !== 1'b1 || bus.reg_load_req_out !== 1'b1) begin
      errs++; $display("FAIL b2b_restart: busy=%b req=%b expected 1 1", bus.load_busy_out, bus.reg_load_req_out);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_full_load();
    test_valid_gaps();
    test_ready_delay();
    test_zero_size();
    test_reset_abort();
    test_req_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mpu_load.md
MPU_LOAD -- requirements
Module: mpu_load

Interface
REQ-001 Parameter: MBITS, default 2, row-count width minus 1; M and i fields are MBITS+1 bits.
REQ-002 Parameter: NBITS, default 2, column-count width minus 1; N and j fields are NBITS+1 bits.
REQ-003 Parameter: MATRIX_REG_BITS, default 3, matrix-register address width minus 1.
REQ-004 Parameter: FP_BITS, default 32, element width (float_sp).
REQ-005 Port: clk, input, 1, the block's only clock; all state changes on its rising edge.
REQ-006 Port: rst, input, 1, reset; asynchronous and active-low.
REQ-007 Port: load_req_in, input, 1, start-load request; sampled in LOAD_IDLE only.
REQ-008 Port: mem_m_load_size_in, input, MBITS+1, total rows M; sampled with load_req_in.
REQ-009 Port: mem_n_load_size_in, input, NBITS+1, total columns N; sampled with load_req_in.
REQ-010 Port: mem_load_addr_in, input, MATRIX_REG_BITS+1, destination register address; sampled with load_req_in.
REQ-011 Port: mem_load_valid_in, input, 1, mem_load_element_in holds a valid element.
REQ-012 Port: mem_load_element_in, input, FP_BITS, incoming element in row-major order.
REQ-013 Port: mem_load_ack_out, output, 1, element consumed this cycle.
REQ-014 Port: reg_load_ready_in, input, 1, register file grants the load.
REQ-015 Port: reg_load_req_out, output, 1, request to the register file.
REQ-016 Port: reg_load_en_out, output, 1, write strobe to the register file.
REQ-017 Port: reg_load_element_out, output, FP_BITS, element to write.
REQ-018 Port: reg_i_load_loc_out, output, MBITS+1, row index i of the write.
REQ-019 Port: reg_j_load_loc_out, output, NBITS+1, column index j of the write.
REQ-020 Port: reg_m_load_size_out, output, MBITS+1, latched M.
REQ-021 Port: reg_n_load_size_out, output, NBITS+1, latched N.
REQ-022 Port: reg_load_addr_out, output, MATRIX_REG_BITS+1, latched address.
REQ-023 Port: load_busy_out, output, 1, high in every state except LOAD_IDLE.
REQ-024 Port: load_done_out, output, 1, one-cycle completion pulse.

Function
REQ-025 States SHALL be LOAD_IDLE, LOAD_REQUEST, LOAD_MATRIX and LOAD_DONE.
REQ-026 LOAD_IDLE with load_req_in=1 SHALL latch M, N and address, clear the row pointer (rp) and column pointer (cp), and go to LOAD_REQUEST.
REQ-027 If the latched M or N is 0, the FSM SHALL go from LOAD_IDLE directly to LOAD_DONE; no reg_load_req_out, ack or write occurs.
REQ-028 LOAD_REQUEST SHALL drive reg_load_req_out=1 and go to LOAD_MATRIX on the first cycle with reg_load_ready_in=1.
REQ-029 In LOAD_MATRIX, mem_load_ack_out SHALL equal mem_load_valid_in (combinational); it is 0 in all other states.
REQ-030 An accepted element SHALL be registered with i=rp and j=cp, and reg_load_en_out=1 SHALL be asserted in the next cycle only (latency 1).
REQ-031 When no element is accepted, reg_load_en_out SHALL be 0 the following cycle, and the data and index outputs SHALL hold their values.
REQ-032 The pointers SHALL advance in row-major order on each accept: if cp=N-1, then cp becomes 0 and rp increments; otherwise cp increments.
REQ-033 Accepting the element at rp=M-1 and cp=N-1 SHALL move the FSM to LOAD_DONE; the pointers SHALL not advance past it.
REQ-034 LOAD_DONE SHALL last exactly one cycle with load_done_out=1, then return to LOAD_IDLE.
REQ-035 The final reg_load_en_out pulse SHALL coincide with the LOAD_DONE cycle.
REQ-036 load_req_in SHALL be ignored outside LOAD_IDLE; a request held high through LOAD_DONE SHALL start a new load from LOAD_IDLE on the next cycle.
REQ-037 Exactly M*N writes SHALL occur per load, with no duplicate or skipped (i,j).
REQ-038 reg_m_load_size_out, reg_n_load_size_out and reg_load_addr_out SHALL hold their latched values until the next accepted load_req_in.

Reset
REQ-039 rst=0 SHALL asynchronously force LOAD_IDLE, clear rp and cp, and drive every output and latched register to 0.
REQ-040 Reset mid-load SHALL abort the load; no reg_load_en_out pulse SHALL follow deassertion.
REQ-041 After rst returns to 1, the FSM SHALL stay in LOAD_IDLE until load_req_in=1.

Verification
REQ-042 M=2, N=3, addr=5, ready and valid held high -> 6 writes with (i,j) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), data in order; done pulse on the cycle of write (1,2).
REQ-043 M=2, N=2, valid toggling 1,0,1,0 -> acks only on valid cycles; 4 writes spaced to match; the index outputs hold during gaps.
REQ-044 reg_load_ready_in delayed 5 cycles -> reg_load_req_out high for 5 cycles; no ack before the grant.
REQ-045 M=0, N=3 -> LOAD_IDLE, LOAD_DONE, LOAD_IDLE; a single done pulse; zero acks and zero writes.
REQ-046 rst=0 after 3 of 4 elements are accepted -> all outputs 0 immediately, no further writes; a fresh 1x1 load afterwards completes with one write at (0,0).
REQ-047 load_req_in pulsed during LOAD_MATRIX -> ignored; the current load completes unaltered.
